// File: rtl/pc_unit.sv
// ---------------------------------------------------------------------------
// pc_unit -- program counter with boot delay, redirect and misaligned-trap
//
// After reset release the unit idles for BOOT_CYCLES cycles at RESET_VECTOR,
// then fetches sequentially. Fetch can be stalled or redirected. A redirect
// to a non-word-aligned target never reaches pc_actual. Instead, the PC
// jumps to TRAP_VECTOR, the offending target is captured, and a one-cycle
// TRAP state blanks fetch_valid before fetching resumes at TRAP_VECTOR.
//
// Parameters
//   XLEN          PC / target width
//   RESET_VECTOR  PC value during reset and boot
//   TRAP_VECTOR   PC value loaded on a misaligned redirect
//   BOOT_CYCLES   idle cycles after reset release (1..15)
//
// Ports
//   CLK              in   clock, rising edge
//   reset            in   asynchronous active-low reset
//   stall            in   hold PC (ignored when a redirect is present)
//   redirect_valid   in   branch/jump request this cycle
//   redirect_target  in   branch/jump destination
//   pc_actual        out  current fetch address (registered)
//   pc_plus4         out  pc_actual + 4, combinational, wraps
//   fetch_valid      out  pc_actual is a valid fetch address (registered)
//   fault            out  one-cycle pulse on a misaligned redirect
//   fault_addr       out  last misaligned redirect target (sticky)
// ---------------------------------------------------------------------------
module pc_unit #(
    parameter int unsigned        XLEN         = 32,
    parameter logic [XLEN-1:0]    RESET_VECTOR = 32'h0000_0000,
    parameter logic [XLEN-1:0]    TRAP_VECTOR  = 32'h0000_0100,
    parameter int unsigned        BOOT_CYCLES  = 2
) (
    input  logic            CLK,
    input  logic            reset,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    output logic [XLEN-1:0] pc_actual,
    output logic [XLEN-1:0] pc_plus4,
    output logic            fetch_valid,
    output logic            fault,
    output logic [XLEN-1:0] fault_addr
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        TRAP = 2'd2
    } state_t;

    // Boot ends on the edge where the counter already holds BOOT_CYCLES-1,
    // so fetch_valid rises exactly BOOT_CYCLES edges after release.
    localparam logic [3:0] BOOT_LAST = 4'(BOOT_CYCLES - 1);

    state_t     state;
    logic [3:0] boot_cnt;
    logic       misaligned;

    assign pc_plus4   = pc_actual + XLEN'(4);
    assign misaligned = redirect_valid && (redirect_target[1:0] != 2'b00);

    // NOTE: every register below is written with <= so that all of them
    // sample the same pre-edge values; mixing in = here would create
    // order-dependent simulation and a mismatch against synthesis.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state       <= BOOT;
            boot_cnt    <= '0;
            pc_actual   <= RESET_VECTOR;
            fetch_valid <= 1'b0;
            fault       <= 1'b0;
            fault_addr  <= '0;
        end else begin
            // fault is a pulse: cleared every cycle unless set below.
            fault <= 1'b0;
            case (state)
                BOOT: begin
                    // stall and redirect are ignored while booting.
                    if (boot_cnt == BOOT_LAST) begin
                        state       <= RUN;
                        fetch_valid <= 1'b1;
                    end else begin
                        boot_cnt <= boot_cnt + 4'd1;
                    end
                end
                RUN: begin
                    // Priority: misaligned redirect > aligned redirect > stall > increment.
                    if (misaligned) begin
                        pc_actual   <= TRAP_VECTOR;
                        fault_addr  <= redirect_target;
                        fault       <= 1'b1;
                        fetch_valid <= 1'b0;
                        state       <= TRAP;
                    end else if (redirect_valid) begin
                        pc_actual <= redirect_target;
                    end else if (!stall) begin
                        pc_actual <= pc_plus4;
                    end
                end
                TRAP: begin
                    // One bubble cycle; PC stays at TRAP_VECTOR and all
                    // inputs are ignored. Fetch resumes at TRAP_VECTOR.
                    state       <= RUN;
                    fetch_valid <= 1'b1;
                end
                default: begin
                    state       <= BOOT;
                    fetch_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_unit.sv
// ---------------------------------------------------------------------------
// tb_pc_unit -- directed self-checking bench for pc_unit (default params).
// Inputs change and outputs are sampled 1 ns after each rising edge.
// ---------------------------------------------------------------------------
module tb_pc_unit;

    logic        CLK;
    logic        reset;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic [31:0] pc_actual;
    logic [31:0] pc_plus4;
    logic        fetch_valid;
    logic        fault;
    logic [31:0] fault_addr;

    int errors = 0;
    int checks = 0;

    pc_unit dut (
        .CLK             (CLK),
        .reset           (reset),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .pc_actual       (pc_actual),
        .pc_plus4        (pc_plus4),
        .fetch_valid     (fetch_valid),
        .fault           (fault),
        .fault_addr      (fault_addr)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Checks the full observable state in one call.
    task automatic expect_state(input string tag, input logic [31:0] pc,
                                input logic fv, input logic flt, input logic [31:0] fa);
        check({tag, ".pc"},    pc_actual,         pc);
        check({tag, ".fv"},    32'(fetch_valid),  32'(fv));
        check({tag, ".fault"}, 32'(fault),        32'(flt));
        check({tag, ".faddr"}, fault_addr,        fa);
    endtask

    initial begin
        reset           = 1'b0;
        stall           = 1'b0;
        redirect_valid  = 1'b0;
        redirect_target = 32'h0;
        #1;
        expect_state("rst", 32'h0, 1'b0, 1'b0, 32'h0);
        step();
        step();
        expect_state("rst_hold", 32'h0, 1'b0, 1'b0, 32'h0);

        // Release between edges; boot ignores stall/redirect.
        reset           = 1'b1;
        stall           = 1'b1;
        redirect_valid  = 1'b1;
        redirect_target = 32'h0000_0042;
        step();
        expect_state("boot1", 32'h0, 1'b0, 1'b0, 32'h0);
        stall          = 1'b0;
        redirect_valid = 1'b0;
        step();
        expect_state("boot2", 32'h0, 1'b1, 1'b0, 32'h0);
        check("pc_plus4_0", pc_plus4, 32'h4);

        // Sequential fetch.
        step(); check("seq4", pc_actual, 32'h4);
        step(); check("seq8", pc_actual, 32'h8);

        // Stall at 0x8 for three cycles, then resume.
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_hold", pc_actual, 32'h8);
        end
        stall = 1'b0;
        step(); check("unstall", pc_actual, 32'hC);

        // Aligned redirect wins over stall.
        stall           = 1'b1;
        redirect_valid  = 1'b1;
        redirect_target = 32'h0000_0040;
        step(); check("redir", pc_actual, 32'h40);
        stall          = 1'b0;
        redirect_valid = 1'b0;
        step(); check("redir_next", pc_actual, 32'h44);
        check("pc_plus4_44", pc_plus4, 32'h48);

        // Misaligned redirect -> trap.
        redirect_valid  = 1'b1;
        redirect_target = 32'h0000_0042;
        step();
        expect_state("trap", 32'h100, 1'b0, 1'b1, 32'h42);
        // Inputs during TRAP are ignored.
        redirect_target = 32'h0000_0080;
        stall           = 1'b1;
        step();
        expect_state("post_trap", 32'h100, 1'b1, 1'b0, 32'h42);
        redirect_valid = 1'b0;
        stall          = 1'b0;
        step(); check("trap_seq", pc_actual, 32'h104);

        // Wrap at the top of the address space.
        redirect_valid  = 1'b1;
        redirect_target = 32'hFFFF_FFFC;
        step();
        expect_state("top", 32'hFFFF_FFFC, 1'b1, 1'b0, 32'h42);
        check("pc_plus4_wrap", pc_plus4, 32'h0);
        redirect_valid = 1'b0;
        step();
        expect_state("wrap", 32'h0, 1'b1, 1'b0, 32'h42);

        // Trap, then async reset in the middle of the TRAP cycle.
        redirect_valid  = 1'b1;
        redirect_target = 32'h0000_0013;
        step();
        expect_state("trap2", 32'h100, 1'b0, 1'b1, 32'h13);
        redirect_valid = 1'b0;
        #2 reset = 1'b0;
        #1;
        expect_state("async_rst", 32'h0, 1'b0, 1'b0, 32'h0);
        #1 reset = 1'b1;
        step();
        expect_state("reboot1", 32'h0, 1'b0, 1'b0, 32'h0);
        step();
        expect_state("reboot2", 32'h0, 1'b1, 1'b0, 32'h0);
        step(); check("reboot_seq", pc_actual, 32'h4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pc_unit.md
PC_UNIT -- requirements
Module: pc_unit

Interface
- REQ-001: Parameter XLEN, default 32, sets the width of the PC and redirect target.
- REQ-002: Parameter RESET_VECTOR, default 32'h0000_0000, is the PC value at reset and during boot.
- REQ-003: Parameter TRAP_VECTOR, default 32'h0000_0100, is the PC loaded on a misaligned redirect.
- REQ-004: Parameter BOOT_CYCLES, default 2, range 1..15, is the number of idle cycles after reset release before fetch starts.
- REQ-005: CLK  input  1  is the single clock; all state updates on its rising edge.
- REQ-006: reset  input  1  is an asynchronous, active-low reset.
- REQ-007: stall  input  1  holds the PC when high, unless a redirect is present.
- REQ-008: redirect_valid  input  1  requests a branch or jump this cycle.
- REQ-009: redirect_target  input  XLEN  is the branch or jump destination.
- REQ-010: pc_actual  output  XLEN  is the current fetch address (registered).
- REQ-011: pc_plus4  output  XLEN  is pc_actual+4, combinational, modulo 2^XLEN.
- REQ-012: fetch_valid  output  1  is high when pc_actual is a valid fetch address.
- REQ-013: fault  output  1  is a one-cycle pulse on a misaligned redirect.
- REQ-014: fault_addr  output  XLEN  holds the last offending redirect_target (registered, sticky).

Function
- REQ-015: The FSM SHALL have three states: BOOT, RUN and TRAP.
- REQ-016: BOOT: pc_actual=RESET_VECTOR and fetch_valid=0; a boot counter increments each cycle; the FSM moves to RUN when the count reaches BOOT_CYCLES-1; stall and redirect are ignored.
- REQ-017: RUN with redirect_valid=1 and redirect_target[1:0]==0: pc_actual<=redirect_target on the next edge, regardless of stall.
- REQ-018: RUN with redirect_valid=1 and redirect_target[1:0]!=0: pc_actual<=TRAP_VECTOR, fault_addr<=redirect_target, fault=1 for exactly one cycle, and the FSM moves to TRAP.
- REQ-019: RUN with redirect_valid=0 and stall=1: pc_actual holds.
- REQ-020: RUN with redirect_valid=0 and stall=0: pc_actual<=pc_actual+4, wrapping modulo 2^XLEN (32'hFFFF_FFFC -> 32'h0000_0000, no flag).
- REQ-021: fetch_valid SHALL be 1 in RUN and 0 in BOOT and TRAP.
- REQ-022: TRAP lasts exactly one cycle with fetch_valid=0 and the PC held at TRAP_VECTOR; the FSM then returns to RUN, where fetch starts at TRAP_VECTOR.
- REQ-023: Inputs presented during TRAP SHALL be ignored.
- REQ-024: Priority in RUN SHALL be: misaligned redirect > aligned redirect > stall > increment.
- REQ-025: A misaligned redirect_target SHALL never appear on pc_actual.

Reset
- REQ-026: While reset=0: pc_actual=RESET_VECTOR, FSM=BOOT, boot counter=0, fetch_valid=0, fault=0, fault_addr=0, all applied asynchronously.
- REQ-027: Reset asserted mid-operation, including in TRAP or during a stall, SHALL abort immediately to the reset values above.
- REQ-028: After release, the first fetch_valid=1 SHALL occur exactly BOOT_CYCLES rising edges later.

Verification
- REQ-029: Defaults; release reset, no stall -> fetch_valid rises after 2 edges; pc_actual then steps 0x0, 0x4, 0x8, 0xC on successive cycles.
- REQ-030: In RUN at pc=0x8, stall=1 for 3 cycles -> pc holds 0x8; on stall=0, next value is 0xC.
- REQ-031: stall=1 with redirect_valid=1, target=0x40 -> pc=0x40 next cycle; the following cycle, with stall=0, pc=0x44.
- REQ-032: redirect target=0x42 -> fault pulse of 1 cycle, fault_addr=0x42, pc=0x100, fetch_valid=0 for 1 cycle; then 0x100 is valid and 0x104 follows.
- REQ-033: Redirect to 0xFFFF_FFFC, then increment -> pc=0x0000_0000, no fault.
- REQ-034: reset=0 asserted between edges during TRAP -> outputs go to reset values immediately, without waiting for CLK; after release, the full boot sequence repeats.
